t04_mem_responder: RTL and testbench

// - Memory-side end of the t04 CPU request interface: accepts one fetch or data request from the datapath,

---
 rtl/t04_mem_responder.sv | 153 +++++++++++++++
 tb/tb_t04_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/t04_mem_responder.sv
// rtl/t04_mem_responder.sv - memory-side responder: one CPU fetch/load/store per Wishbone-classic cycle
module t04_mem_responder #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] FETCH_ERR = 32'h0000_0013,
  parameter logic [31:0] DATA_ERR  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_fetch,
  output logic [31:0] instruction,
  output logic [31:0] memload,
  output logic        i_ack,
  output logic        d_ack,
  output logic        bus_err,
  output logic        busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_ACK} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] mem_q, mem_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      kind_q  <= K_FETCH;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      timer_q <= '0;
      instr_q <= '0;
      mem_q   <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      timer_q <= timer_d;
      instr_q <= instr_d;
      mem_q   <= mem_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    timer_d = timer_q;
    instr_d = instr_q;
    mem_d   = mem_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_write || req_read || req_fetch) begin
          adr_d   = {req_addr[31:2], 2'b00};
          cyc_d   = 1'b1;
          timer_d = '0;
          state_d = ST_BUS;
          // Store beats load when both are raised; the load is simply dropped.
          if (req_write) begin
            kind_d = K_STORE;
            dat_d  = req_wdata;
            we_d   = 1'b1;
          end else begin
            kind_d = req_read ? K_LOAD : K_FETCH;
            dat_d  = '0;
            we_d   = 1'b0;
          end
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_ACK;
          i_ack_d = (kind_q == K_FETCH);
          d_ack_d = (kind_q != K_FETCH);
          if (kind_q == K_FETCH) instr_d = wb_dat_i;
          if (kind_q == K_LOAD)  mem_d   = wb_dat_i;
        end else if (timer_q == TMAX) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_ACK;
          err_d   = 1'b1;
          i_ack_d = (kind_q == K_FETCH);
          d_ack_d = (kind_q != K_FETCH);
          if (kind_q == K_FETCH) instr_d = FETCH_ERR;
          if (kind_q == K_LOAD)  mem_d   = DATA_ERR;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign instruction = instr_q;
  assign memload     = mem_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign bus_err     = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = cyc_q ? 4'hF : 4'h0;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule

// File: tb/tb_t04_mem_responder.sv
// tb/tb_t04_mem_responder.sv - table-driven scoreboard bench for t04_mem_responder
module tb_t04_mem_responder;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic        req_fetch = 1'b0;
  logic [31:0] instruction, memload;
  logic        i_ack, d_ack, bus_err, busy;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  t04_mem_responder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write), .req_fetch(req_fetch),
    .instruction(instruction), .memload(memload),
    .i_ack(i_ack), .d_ack(d_ack), .bus_err(bus_err), .busy(busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr, rd, fe;
    logic [31:0] addr, wdata;
    int          waitc;      // bus wait cycles before ack; negative = never ack
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          i_ack, d_ack, err;
    logic [31:0] instr, mem;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[11];
  logic [31:0] m_instr = '0;
  logic [31:0] m_mem = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e, x;
    bit          is_st, is_ld, is_fe, err, done;
    int          n, bus_n;
    logic [31:0] exp_adr;
    is_st = v.wr;
    is_ld = !v.wr && v.rd;
    is_fe = !v.wr && !v.rd && v.fe;
    err   = (v.waitc < 0) || (v.waitc >= TO);
    if (is_fe) m_instr = err ? 32'h0000_0013 : v.rdata;
    if (is_ld) m_mem   = err ? 32'hDEAD_BEEF : v.rdata;
    e.i_ack = is_fe;
    e.d_ack = !is_fe;
    e.err   = err;
    e.instr = m_instr;
    e.mem   = m_mem;
    e.lat   = err ? TO + 1 : v.waitc + 2;
    sbq.push_back(e);
    exp_adr = {v.addr[31:2], 2'b00};

    @(negedge clk);
    req_write = v.wr; req_read = v.rd; req_fetch = v.fe;
    req_addr = v.addr; req_wdata = v.wdata;
    n = 0; bus_n = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (wb_cyc_o) begin
        bus_n++;
        chk("wb_adr", wb_adr_o, exp_adr);
        chk("wb_we", {31'b0, wb_we_o}, {31'b0, is_st});
        chk("wb_sel", {28'b0, wb_sel_o}, 32'hF);
        chk("wb_dat_o", wb_dat_o, is_st ? v.wdata : 32'h0);
        chk("wb_stb", {31'b0, wb_stb_o}, 32'h1);
        chk("busy_bus", {31'b0, busy}, 32'h1);
        if (v.waitc >= 0 && bus_n == v.waitc + 1) begin
          wb_ack_i = 1'b1;
          wb_dat_i = v.rdata;
        end else begin
          wb_ack_i = 1'b0;
          wb_dat_i = $urandom;
        end
      end else begin
        wb_ack_i = 1'b0;
      end
      if (i_ack || d_ack) begin
        done = 1;
        req_write = 0; req_read = 0; req_fetch = 0;
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack actual=1 required=0");
        end else begin
          x = sbq.pop_front();
          chk("i_ack", {31'b0, i_ack}, {31'b0, x.i_ack});
          chk("d_ack", {31'b0, d_ack}, {31'b0, x.d_ack});
          chk("bus_err", {31'b0, bus_err}, {31'b0, x.err});
          chk("instruction", instruction, x.instr);
          chk("memload", memload, x.mem);
          chk("latency", n, x.lat);
          chk("bus_cycles", bus_n, err ? TO : v.waitc + 1);
          chk("cyc_at_ack", {31'b0, wb_cyc_o}, 32'h0);
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL ack_wait actual=none required=ack_within_40_cycles");
      if (sbq.size() != 0) void'(sbq.pop_front());
      req_write = 0; req_read = 0; req_fetch = 0; wb_ack_i = 0;
    end
    @(negedge clk);
    chk("ack_pulse_width", {30'b0, i_ack, d_ack}, 32'h0);
    chk("busy_after", {31'b0, busy}, 32'h0);
    chk("cyc_after", {31'b0, wb_cyc_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr rd fe addr           wdata          wait rdata
    vecs[0]  = '{0, 0, 1, 32'h0000_0104, 32'h0,         2,  32'h00A0_0093};
    vecs[1]  = '{1, 0, 0, 32'h2000_0003, 32'h1234_5678, 1,  32'h5555_AAAA};
    vecs[2]  = '{0, 1, 0, 32'h3000_000A, 32'h0,         0,  32'hCAFE_F00D};
    vecs[3]  = '{0, 1, 0, 32'h4000_0000, 32'h0,         -1, 32'h0};
    vecs[4]  = '{0, 0, 1, 32'h0000_0200, 32'h0,         -1, 32'h0};
    vecs[5]  = '{0, 0, 1, 32'h0000_0204, 32'h0,         0,  32'h1111_1111};
    vecs[6]  = '{0, 0, 1, 32'h0000_0208, 32'h0,         0,  32'h2222_2222};
    vecs[7]  = '{0, 1, 0, 32'h5000_0010, 32'h0,         TO - 1, 32'h7777_0001};
    vecs[8]  = '{1, 0, 0, 32'h6000_0020, 32'hABCD_0123, -1, 32'h0};
    vecs[9]  = '{1, 1, 1, 32'h7000_0004, 32'h0BAD_F00D, 0,  32'h9999_9999};
    vecs[10] = '{0, 0, 1, 32'h7000_0004, 32'h0,         1,  32'h0000_0033};

    repeat (3) @(negedge clk);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_memload", memload, 32'h0);
    chk("rst_acks", {29'b0, i_ack, d_ack, bus_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_wb_adr", wb_adr_o, 32'h0);
    chk("rst_wb_dat", wb_dat_o, 32'h0);
    chk("rst_wb_ctl", {25'b0, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o}, 32'h0);
    rst = 1'b1;

    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_ignored", {29'b0, i_ack, d_ack, busy}, 32'h0);
    end
    chk("idle_ack_instr", instruction, 32'h0);
    chk("idle_ack_mem", memload, 32'h0);
    wb_ack_i = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    @(negedge clk);
    req_fetch = 1'b1; req_addr = 32'h0000_0300;
    @(negedge clk);
    chk("mid_rst_bus1", {31'b0, wb_cyc_o}, 32'h1);
    @(negedge clk);
    chk("mid_rst_bus2", {31'b0, wb_cyc_o}, 32'h1);
    rst = 1'b0;
    req_fetch = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_acks", {30'b0, i_ack, d_ack}, 32'h0);
    rst = 1'b1;
    m_instr = '0;
    m_mem   = '0;
    @(negedge clk);
    chk("post_rst_acks", {30'b0, i_ack, d_ack}, 32'h0);
    run_vec(vecs[5]);
    run_vec(vecs[2]);

    chk("scoreboard_empty", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
